system_sysid_checker: RTL and testbench

//  Avalon-MM read master that sits directly downstream of the system ID slave (control_slave).
//  On start, it reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expectations.
//  It reports pass/fail to boot/status logic so mismatched bitstream/software pairs are flagged before the CPU is released.

---
 rtl/system_pkg.sv | 22 ++
 rtl/system_sysid_timeout.sv | 48 ++++
 rtl/system_sysid_checker.sv | 131 +++++++++++++
 tb/tb_system_sysid_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/system_pkg.sv
// Shared definitions for the system ID checker block.
//   - FSM state encoding for the checker sequencer
//   - word addresses of the sysid slave registers
//   - counter widths for the stall/retry supervisor
package system_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD_ID = 3'd1;
  localparam state_t ST_RD_TS = 3'd2;
  localparam state_t ST_CMP   = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Stall counter covers TIMEOUT_CYCLES up to 65535, retry counter up to 15.
  localparam int TMO_W = 16;
  localparam int RTY_W = 4;

endpackage

// File: rtl/system_sysid_timeout.sv
// Stall/retry supervisor for one outstanding Avalon-MM read.
//   clock, reset : system clock, async active-high reset
//   clear        : restart both counters (new check or read accepted)
//   stall        : read strobe is high and the slave is stalling this cycle
//   expire       : this stalled cycle is the TIMEOUT_CYCLES-th of the attempt
//   exhausted    : expire with the retry budget already used up
module system_sysid_timeout
  import system_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expire,
  output logic exhausted
);

  localparam logic [TMO_W-1:0] STALL_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX  = RTY_W'(MAX_RETRIES);

  logic [TMO_W-1:0] stall_cnt;
  logic [RTY_W-1:0] retry_cnt;

  // Expiry only happens on a stalled cycle, so an accept in the same cycle
  // the count would be reached always wins.
  assign expire    = stall && (stall_cnt == STALL_LAST);
  assign exhausted = expire && (retry_cnt == RETRY_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      retry_cnt <= '0;
    end else if (clear) begin
      stall_cnt <= '0;
      retry_cnt <= '0;
    end else if (expire) begin
      // Each re-issued attempt gets a fresh stall budget.
      stall_cnt <= '0;
      if (!exhausted) retry_cnt <= retry_cnt + 1'b1;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID word (address 0) and
// timestamp word (address 1) and compares them with build-time values.
//   clock, reset      : system clock, async active-high reset
//   start             : pulse to begin a check (ignored unless idle)
//   avm_address/read  : registered read request to the sysid slave
//   avm_readdata      : read data, taken when read && !waitrequest
//   avm_waitrequest   : slave stall
//   busy              : check in progress (RD_ID/RD_TS/CMP)
//   done, pass        : sticky completion / overall result
//   id_mismatch       : sticky, ID word differs from EXPECTED_ID
//   ts_mismatch       : sticky, timestamp differs from EXPECTED_TS
//   timeout_err       : sticky, a read ran out of retries
//   captured_id/ts    : last words read from address 0 / 1
module system_sysid_checker
  import system_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1395705710,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3,
  parameter int          AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  state_t state, state_nx;
  logic   pending;
  logic   in_rd, go, accept, stall, expire, exhausted;
  logic   read_nx, addr_nx;

  assign in_rd  = (state == ST_RD_ID) || (state == ST_RD_TS);
  assign go     = (state == ST_IDLE) && (start || pending);
  assign accept = in_rd && avm_read && !avm_waitrequest;
  assign stall  = in_rd && avm_read && avm_waitrequest;

  system_sysid_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clear     (go || accept),
    .stall     (stall),
    .expire    (expire),
    .exhausted (exhausted)
  );

  // State register plus the registered bus outputs derived from next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
    end else begin
      state       <= state_nx;
      avm_read    <= read_nx;
      avm_address <= addr_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (go) state_nx = ST_RD_ID;
      ST_RD_ID: if (accept) state_nx = ST_RD_TS;
                else if (exhausted) state_nx = ST_FIN;
      ST_RD_TS: if (accept) state_nx = ST_CMP;
                else if (exhausted) state_nx = ST_FIN;
      ST_CMP:   state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output logic. The read strobe drops for exactly one cycle after a
  // non-final expiry, then the same read is re-issued.
  always_comb begin
    busy    = (state == ST_RD_ID) || (state == ST_RD_TS) || (state == ST_CMP);
    read_nx = ((state_nx == ST_RD_ID) || (state_nx == ST_RD_TS)) && !expire;
    addr_nx = (state_nx == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  // Capture registers and sticky status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= (AUTO_START != 0);
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout_err <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      if (go) begin
        pending     <= 1'b0;
        done        <= 1'b0;
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (accept && state == ST_RD_ID) captured_id <= avm_readdata;
      if (accept && state == ST_RD_TS) captured_ts <= avm_readdata;
      if (exhausted) timeout_err <= 1'b1;
      if (state == ST_CMP) begin
        id_mismatch <= (captured_id != EXPECTED_ID);
        ts_mismatch <= (captured_ts != EXPECTED_TS);
        pass        <= (captured_id == EXPECTED_ID) &&
                       (captured_ts == EXPECTED_TS) && !timeout_err;
      end
      if (state_nx == ST_FIN) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_system_sysid_checker.sv
module tb_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1395705710;
  localparam int T = 12;
  localparam int R = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout_err;
  logic [31:0] captured_id, captured_ts;

  always #5 clock = ~clock;

  system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(T), .MAX_RETRIES(R), .AUTO_START(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .pass(pass),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch),
    .timeout_err(timeout_err),
    .captured_id(captured_id), .captured_ts(captured_ts)
  );

  // Slave: stalls the k-th word for k read-active cycles, then returns data.
  int          sl_k_id = 0, sl_k_ts = 0, sl_cnt = 0;
  logic [31:0] sl_d_id = EXP_ID, sl_d_ts = EXP_TS;
  assign avm_waitrequest = (sl_cnt < (avm_address ? sl_k_ts : sl_k_id));
  assign avm_readdata    = avm_address ? sl_d_ts : sl_d_id;
  always @(posedge clock) begin
    if (!busy) sl_cnt <= 0;
    else if (avm_read && avm_waitrequest) sl_cnt <= sl_cnt + 1;
    else if (avm_read) sl_cnt <= 0;
  end

  // Count read attempts as rising edges of the read strobe.
  int   rises = 0;
  logic prev_rd = 1'b0;
  always @(posedge clock) begin
    prev_rd <= avm_read;
    if (avm_read && !prev_rd) rises <= rises + 1;
  end

  typedef struct {
    int cyc; int att;
    logic pass, idm, tsm, to;
    logic [31:0] cid, cts;
  } exp_t;

  typedef struct {
    int kid, kts;
    logic [31:0] did, dts;
    int cyc;
    logic pass, idm, tsm, to;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  logic [31:0] cap_id = 0, cap_ts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Transaction-level reference: a read needing k stalled cycles suffers
  // k/T timeouts; each timeout costs one idle cycle; more than R fails.
  function automatic exp_t model(input int kid, input int kts,
                                 input logic [31:0] did, input logic [31:0] dts,
                                 input logic [31:0] pcid, input logic [31:0] pcts);
    exp_t e;
    int eid, ets, fail_len;
    eid = kid / T; ets = kts / T;
    fail_len = (R + 1) * T + R;
    e.cid = pcid; e.cts = pcts;
    e.pass = 0; e.idm = 0; e.tsm = 0; e.to = 0;
    if (eid > R) begin
      e.cyc = fail_len + 1; e.to = 1; e.att = R + 1;
    end else begin
      e.cid = did;
      if (ets > R) begin
        e.cyc = 1 + (kid + eid + 1) + fail_len; e.to = 1; e.att = 1 + eid + R;
      end else begin
        e.cts = dts;
        e.cyc = (kid + eid + 1) + (kts + ets + 1) + 2;
        e.att = 1 + eid + ets;
        e.idm = (did != EXP_ID); e.tsm = (dts != EXP_TS);
        e.pass = !e.idm && !e.tsm;
      end
    end
    return e;
  endfunction

  task automatic set_slave(input int kid, input int kts,
                           input logic [31:0] did, input logic [31:0] dts);
    sl_k_id = kid; sl_k_ts = kts; sl_d_id = did; sl_d_ts = dts;
  endtask

  // Count cycles until done; cycle 1 is the first read cycle.
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      start = 1'b0;
      if (done) begin cyc = c; break; end
    end
    tick();
  endtask

  task automatic check_run(input string tag, input exp_t e, input int cyc, input int att);
    chk({tag, " done_cycle"}, cyc, e.cyc);
    chk({tag, " attempts"}, att, e.att);
    chk({tag, " pass"}, pass, e.pass);
    chk({tag, " id_mismatch"}, id_mismatch, e.idm);
    chk({tag, " ts_mismatch"}, ts_mismatch, e.tsm);
    chk({tag, " timeout_err"}, timeout_err, e.to);
    chk({tag, " captured_id"}, captured_id, e.cid);
    chk({tag, " captured_ts"}, captured_ts, e.cts);
    cap_id = e.cid; cap_ts = e.cts;
  endtask

  task automatic run_vec(input string tag, input int kid, input int kts,
                         input logic [31:0] did, input logic [31:0] dts, output exp_t e);
    int cyc, r0;
    set_slave(kid, kts, did, dts);
    e = model(kid, kts, did, dts, cap_id, cap_ts);
    r0 = rises;
    start = 1'b1;
    wait_done(200, cyc);
    check_run(tag, e, cyc, rises - r0);
  endtask

  vec_t tbl[10];

  initial begin
    int cyc, r0;
    exp_t e;

    // Hand-computed expectations with T=12, R=2 (fail takes 3*12+2 cycles).
    tbl[0] = '{0,   0,  EXP_ID, EXP_TS,     4,  1, 0, 0, 0};
    tbl[1] = '{0,   0,  32'h1,  EXP_TS,     4,  0, 1, 0, 0};
    tbl[2] = '{0,   10, EXP_ID, EXP_TS,     14, 1, 0, 0, 0};
    tbl[3] = '{999, 0,  EXP_ID, EXP_TS,     39, 0, 0, 0, 1};
    tbl[4] = '{0,   0,  EXP_ID, EXP_TS ^ 1, 4,  0, 0, 1, 0};
    tbl[5] = '{0,   12, EXP_ID, EXP_TS,     17, 1, 0, 0, 0};
    tbl[6] = '{11,  0,  EXP_ID, EXP_TS,     15, 1, 0, 0, 0};
    tbl[7] = '{0,   999, EXP_ID, EXP_TS,    40, 0, 0, 0, 1};
    tbl[8] = '{36,  0,  32'h77, EXP_TS,     39, 0, 0, 0, 1};
    tbl[9] = '{35,  0,  EXP_ID, 32'h1234,   41, 0, 0, 1, 0};

    // Reset state, then the automatic check after release.
    set_slave(0, 0, EXP_ID, EXP_TS);
    repeat (2) @(posedge clock);
    #1;
    chk("reset flags", {avm_read, avm_address, busy, done, pass,
                        id_mismatch, ts_mismatch, timeout_err}, 0);
    chk("reset captured_id", captured_id, 0);
    chk("reset captured_ts", captured_ts, 0);
    r0 = rises;
    reset = 1'b0;
    wait_done(200, cyc);
    check_run("autostart", model(0, 0, EXP_ID, EXP_TS, 0, 0), cyc, rises - r0);

    // Directed table.
    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_vec(tag, tbl[i].kid, tbl[i].kts, tbl[i].did, tbl[i].dts, e);
      chk({tag, " tbl_cycle"}, e.cyc, tbl[i].cyc);
      chk({tag, " tbl_pass"}, pass, tbl[i].pass);
      chk({tag, " tbl_flags"}, {id_mismatch, ts_mismatch, timeout_err},
          {tbl[i].idm, tbl[i].tsm, tbl[i].to});
    end

    // Start pulses during RD_TS and FIN are ignored.
    set_slave(0, 3, EXP_ID, EXP_TS);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = (c == 3 || c == 7);
      if (c == 4) chk("busy start ignored addr", {avm_read, avm_address, busy}, 3'b111);
      if (c == 7) chk("busy start done", done, 1);
    end
    chk("no rerun busy", busy, 0);
    chk("no rerun done/pass", {done, pass}, 2'b11);
    // A fresh start clears flags and reruns.
    set_slave(0, 0, 32'h5, EXP_TS);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart clears", {done, pass}, 2'b00);
    wait_done(200, cyc);
    chk("restart cycle", cyc, 3);
    chk("restart idm", {id_mismatch, pass}, 2'b10);
    cap_id = 32'h5; cap_ts = EXP_TS;

    // Randomized checks against the reference model.
    for (int n = 0; n < 25; n++) begin
      int kid, kts;
      logic [31:0] did, dts;
      kid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
      kts = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
      did = $urandom_range(0, 1) ? EXP_ID : $urandom();
      dts = $urandom_range(0, 1) ? EXP_TS : $urandom();
      run_vec($sformatf("rnd%0d", n), kid, kts, did, dts, e);
    end

    // Reset in the middle of a stalled ID read.
    set_slave(999, 0, EXP_ID, EXP_TS);
    start = 1'b1;
    repeat (3) begin tick(); start = 1'b0; end
    chk("midread avm_read", avm_read, 1);
    #2 reset = 1'b1;
    #1;
    chk("midreset outputs", {avm_read, busy, done, pass, timeout_err}, 0);
    chk("midreset captured", {captured_id, captured_ts}, 64'd0);
    cap_id = 0; cap_ts = 0;
    set_slave(0, 0, EXP_ID, EXP_TS);
    @(posedge clock); #1;
    r0 = rises;
    reset = 1'b0;
    wait_done(200, cyc);
    check_run("rerun", model(0, 0, EXP_ID, EXP_TS, 0, 0), cyc, rises - r0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
